melody_sequencer: RTL

Controller that sequences the tone-generation datapath for song playback. On `start` it walks a synchronous note ROM from address 0. For each note it loads a programmable half-period divider, which drives a square wave on `tone`, and runs a beat-duration counter. Between notes it inserts a fixed silent gap. It sits between the song ROM and the buzzer/audio output pin and is clocked from the system clock.

---
 rtl/melody_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a synchronous note ROM and plays each note as a
// square wave on `tone` for beats x BEAT_CYCLES cycles, then inserts a
// GAP_CYCLES-long silent gap. A beats field of 0 ends the song.
// Optional feature macro: MELODY_LOOP_EN. When defined, the end-of-song word
// restarts playback from address 0 instead of returning to idle.
module melody_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int BEAT_CYCLES = 6250000,
   parameter int GAP_CYCLES  = 250000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic              tone,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] note_idx
);

   // Counter widths; a one-cycle beat or gap still needs a 1-bit register.
   localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_PLAY,
      S_GAP,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [19:0]     half_period;
   logic [19:0]     div_cnt;
   logic [BW-1:0]   beat_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [3:0]      beats_left;

   logic            beat_wrap;
   logic            last_beat;
   logic            gap_end;
   logic            div_term;
   logic            song_end;

   assign beat_wrap = (beat_cnt == BEAT_LAST);
   assign last_beat = beat_wrap && (beats_left == 4'd1);
   assign gap_end   = (gap_cnt == GAP_LAST);
   // A zero half-period is a rest: the divider never reaches a terminal count.
   assign div_term  = (half_period != 20'd0) && (div_cnt == half_period - 20'd1);
   assign song_end  = (rom_data[23:20] == 4'd0);
   assign note_idx  = rom_addr;

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; stop overrides every other transition.
   // NOTE: state_next is defaulted first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_FETCH;
         S_FETCH: state_next = S_LATCH;
         S_LATCH: state_next = song_end ? S_DONE : S_PLAY;
         S_PLAY:  if (last_beat) state_next = S_GAP;
         S_GAP:   if (gap_end) state_next = S_FETCH;
`ifdef MELODY_LOOP_EN
         S_DONE:  state_next = S_FETCH;
`else
         S_DONE:  state_next = S_IDLE;
`endif
         default: state_next = S_IDLE;
      endcase
      if (stop) state_next = S_IDLE;
   end

   // Datapath: address, note registers, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr    <= '0;
         half_period <= '0;
         beats_left  <= '0;
         div_cnt     <= '0;
         beat_cnt    <= '0;
         gap_cnt     <= '0;
         tone        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         // busy/done track the state being entered so they line up with it.
         busy <= (state_next != S_IDLE);
         done <= (state_next == S_DONE);
         if (stop) begin
            // Abort: silence and clear counters, but keep the address.
            tone       <= 1'b0;
            div_cnt    <= '0;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            beats_left <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) rom_addr <= '0;
               end
               S_LATCH: begin
                  beats_left  <= rom_data[23:20];
                  half_period <= rom_data[19:0];
                  div_cnt     <= '0;
                  beat_cnt    <= '0;
                  gap_cnt     <= '0;
                  tone        <= 1'b0;
               end
               S_PLAY: begin
                  if (div_term) begin
                     div_cnt <= '0;
                     tone    <= ~tone;
                  end else if (half_period != 20'd0) begin
                     div_cnt <= div_cnt + 20'd1;
                  end
                  if (beat_wrap) begin
                     beat_cnt   <= '0;
                     beats_left <= beats_left - 4'd1;
                  end else begin
                     beat_cnt <= beat_cnt + BW'(1);
                  end
                  // Leaving for the gap always silences the output.
                  if (last_beat) begin
                     tone    <= 1'b0;
                     gap_cnt <= '0;
                  end
               end
               S_GAP: begin
                  tone <= 1'b0;
                  if (gap_end) begin
                     gap_cnt  <= '0;
                     rom_addr <= rom_addr + ADDR_W'(1);
                  end else begin
                     gap_cnt <= gap_cnt + GW'(1);
                  end
               end
               S_DONE: begin
`ifdef MELODY_LOOP_EN
                  rom_addr <= '0;
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule
